// File: rtl/pixel_packer.sv
// Pixel-side output stage: packs a one-pixel-per-cycle stream into
// NUM_PIXELS-wide words with frame/line syncs, line counts and error flag.
module pixel_packer #(
    parameter int PIX_WIDTH  = 10,
    parameter int NUM_PIXELS = 1,
    parameter int CNT_W      = 16
) (
    input  logic                            clk_pixel_i,
    input  logic                            reset_pixel_n_i,
    input  logic                            pix_vld_i,
    input  logic [PIX_WIDTH-1:0]            pix_data_i,
    input  logic                            sof_i,
    input  logic                            sol_i,
    input  logic                            eol_i,
    input  logic                            eof_i,
    output logic [PIX_WIDTH*NUM_PIXELS-1:0] pixel_data_o,
    output logic [1:0]                      p_odd_o,
    output logic                            line_valid_o,
    output logic                            de_o,
    output logic                            frame_valid_o,
    output logic                            vsync_o,
    output logic                            hsync_o,
    output logic [CNT_W-1:0]                line_pix_cnt_o,
    output logic                            err_o
);

    localparam int WORD_W = PIX_WIDTH * NUM_PIXELS;
    localparam int LANE_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [LANE_W:0] NP_L = (LANE_W + 1)'(NUM_PIXELS);

    if (!(NUM_PIXELS == 1 || NUM_PIXELS == 2 || NUM_PIXELS == 4)) begin : g_bad_np
        $error("pixel_packer: NUM_PIXELS must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                lv_q, lv_d;
    logic [1:0]          podd_q, podd_d;
    logic                fv_q, fv_d;
    logic                vs_q, vs_d;
    logic                hs_q, hs_d;
    logic [CNT_W-1:0]    lcnt_q, lcnt_d;
    logic                err_q, err_d;

    logic                in_line;
    logic                accept;
    logic                full;
    logic [LANE_W:0]     fill;
    logic [WORD_W-1:0]   word;
    logic [CNT_W-1:0]    cnt_inc;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        data_d  = '0;
        lv_d    = 1'b0;
        podd_d  = 2'b00;
        vs_d    = 1'b0;
        hs_d    = 1'b0;
        lcnt_d  = lcnt_q;
        err_d   = err_q;

        in_line = (state_q == LINE);
        accept  = in_line && pix_vld_i && !sof_i;
        word    = buf_q;
        fill    = {1'b0, lane_q};
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        if (accept) begin
            word[int'(lane_q)*PIX_WIDTH +: PIX_WIDTH] = pix_data_i;
            fill  = fill + 1'b1;
            buf_d = word;
            cnt_d = cnt_inc;
        end
        full = accept && (fill == NP_L);

        // Stray pixels outside a line are dropped and flagged.
        if (pix_vld_i && !in_line) begin
            err_d = 1'b1;
        end

        fv_d = (state_q != IDLE) || sof_i;

        unique case (state_q)
            IDLE: begin
                if (sof_i) begin
                    vs_d    = 1'b1;
                    hs_d    = sol_i;
                    state_d = sol_i ? LINE : FRAME;
                end else if (eol_i || eof_i) begin
                    err_d = 1'b1;
                end
            end
            FRAME: begin
                if (sof_i) begin
                    err_d   = 1'b1;
                    vs_d    = 1'b1;
                    hs_d    = sol_i;
                    state_d = sol_i ? LINE : FRAME;
                end else if (sol_i) begin
                    hs_d    = 1'b1;
                    state_d = LINE;
                end else if (eof_i) begin
                    state_d = IDLE;
                end
            end
            LINE: begin
                if (sof_i) begin
                    err_d   = 1'b1;
                    vs_d    = 1'b1;
                    hs_d    = sol_i;
                    state_d = sol_i ? LINE : FRAME;
                    buf_d   = '0;
                    lane_d  = '0;
                    cnt_d   = '0;
                end else begin
                    if (sol_i) begin
                        err_d = 1'b1;
                    end
                    lane_d = fill[LANE_W-1:0];
                    if (full || (eol_i && fill != '0)) begin
                        data_d = word;
                        lv_d   = 1'b1;
                        podd_d = full ? 2'b00 : fill[1:0];
                        buf_d  = '0;
                        lane_d = '0;
                    end
                    if (eol_i) begin
                        lane_d  = '0;
                        lcnt_d  = accept ? cnt_inc : cnt_q;
                        cnt_d   = '0;
                        state_d = eof_i ? IDLE : FRAME;
                    end else if (eof_i) begin
                        // Truncated line: drop the partial word and close the frame.
                        err_d   = 1'b1;
                        buf_d   = '0;
                        lane_d  = '0;
                        cnt_d   = '0;
                        data_d  = '0;
                        lv_d    = 1'b0;
                        podd_d  = 2'b00;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pixel_i or negedge reset_pixel_n_i) begin
        if (!reset_pixel_n_i) begin
            state_q <= IDLE;
            lane_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            lv_q    <= 1'b0;
            podd_q  <= 2'b00;
            fv_q    <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            lcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lv_q    <= lv_d;
            podd_q  <= podd_d;
            fv_q    <= fv_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            lcnt_q  <= lcnt_d;
            err_q   <= err_d;
        end
    end

    assign pixel_data_o   = data_q;
    assign p_odd_o        = podd_q;
    assign line_valid_o   = lv_q;
    assign de_o           = lv_q;
    assign frame_valid_o  = fv_q;
    assign vsync_o        = vs_q;
    assign hsync_o        = hs_q;
    assign line_pix_cnt_o = lcnt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: NUM_PIXELS 1, 2 and 4 instances
// share one stimulus stream; each test checks the relevant instance.
module tb_pixel_packer;

    logic       clk;
    logic       rst_n;
    logic       pix_vld;
    logic [9:0] pix_data;
    logic       sof, sol, eol, eof;

    logic [9:0]  pd1;
    logic [19:0] pd2;
    logic [39:0] pd4;
    logic [1:0]  podd1, podd2, podd4;
    logic        lv1, lv2, lv4, de1, de2, de4;
    logic        fv1, fv2, fv4, vs1, vs2, vs4, hs1, hs2, hs4;
    logic [15:0] lc1, lc2, lc4;
    logic        err1, err2, err4;

    int n_chk = 0;
    int n_err = 0;
    int n_hs1 = 0;
    int n_vs1 = 0;
    int n_de2 = 0;

    pixel_packer #(.PIX_WIDTH(10), .NUM_PIXELS(1), .CNT_W(16)) u_np1 (
        .clk_pixel_i(clk), .reset_pixel_n_i(rst_n),
        .pix_vld_i(pix_vld), .pix_data_i(pix_data),
        .sof_i(sof), .sol_i(sol), .eol_i(eol), .eof_i(eof),
        .pixel_data_o(pd1), .p_odd_o(podd1), .line_valid_o(lv1), .de_o(de1),
        .frame_valid_o(fv1), .vsync_o(vs1), .hsync_o(hs1),
        .line_pix_cnt_o(lc1), .err_o(err1)
    );

    pixel_packer #(.PIX_WIDTH(10), .NUM_PIXELS(2), .CNT_W(16)) u_np2 (
        .clk_pixel_i(clk), .reset_pixel_n_i(rst_n),
        .pix_vld_i(pix_vld), .pix_data_i(pix_data),
        .sof_i(sof), .sol_i(sol), .eol_i(eol), .eof_i(eof),
        .pixel_data_o(pd2), .p_odd_o(podd2), .line_valid_o(lv2), .de_o(de2),
        .frame_valid_o(fv2), .vsync_o(vs2), .hsync_o(hs2),
        .line_pix_cnt_o(lc2), .err_o(err2)
    );

    pixel_packer #(.PIX_WIDTH(10), .NUM_PIXELS(4), .CNT_W(16)) u_np4 (
        .clk_pixel_i(clk), .reset_pixel_n_i(rst_n),
        .pix_vld_i(pix_vld), .pix_data_i(pix_data),
        .sof_i(sof), .sol_i(sol), .eol_i(eol), .eof_i(eof),
        .pixel_data_o(pd4), .p_odd_o(podd4), .line_valid_o(lv4), .de_o(de4),
        .frame_valid_o(fv4), .vsync_o(vs4), .hsync_o(hs4),
        .line_pix_cnt_o(lc4), .err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [9:0] d, input logic so,
                        input logic sl, input logic el, input logic ef);
        pix_vld  = v;
        pix_data = d;
        sof      = so;
        sol      = sl;
        eol      = el;
        eof      = ef;
        @(posedge clk);
        #1;
        if (hs1) n_hs1++;
        if (vs1) n_vs1++;
        if (de2) n_de2++;
    endtask

    task automatic idle();
        step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        pix_vld  = 1'b0;
        pix_data = '0;
        sof      = 1'b0;
        sol      = 1'b0;
        eol      = 1'b0;
        eof      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        chk("rst_fv", fv1, 0);
        chk("rst_de", de1, 0);
        chk("rst_data", pd4, 0);
        chk("rst_podd", podd4, 0);
        chk("rst_lcnt", lc1, 0);
        chk("rst_err", err4, 0);
        chk("rst_vs", vs1, 0);
        chk("rst_hs", hs1, 0);

        // NUM_PIXELS=1: two lines of three pixels
        n_hs1 = 0;
        n_vs1 = 0;
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_vs", vs1, 1);
        chk("t1_fv_rise", fv1, 1);
        for (int ln = 0; ln < 2; ln++) begin
            step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t1_hs", hs1, 1);
            for (int i = 1; i <= 3; i++) begin
                step(1'b1, 10'(ln * 3 + i), 1'b0, 1'b0, i == 3, 1'b0);
                chk("t1_de", de1, 1);
                chk("t1_data", pd1, 64'(ln * 3 + i));
                chk("t1_podd", podd1, 0);
            end
            chk("t1_lcnt", lc1, 3);
        end
        step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_fv_eof1", fv1, 1);
        idle();
        chk("t1_fv_eof2", fv1, 0);
        chk("t1_n_hs", n_hs1, 2);
        chk("t1_n_vs", n_vs1, 1);
        chk("t1_err", err1, 0);

        // NUM_PIXELS=4: seven pixels 0x10..0x16
        do_reset();
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 10'(32'h10 + i), 1'b0, 1'b0, i == 6, 1'b0);
            if (i == 3) begin
                chk("t2_w1_de", de4, 1);
                chk("t2_w1", pd4, {10'h13, 10'h12, 10'h11, 10'h10});
                chk("t2_w1_podd", podd4, 0);
            end else if (i == 6) begin
                chk("t2_w2_de", de4, 1);
                chk("t2_w2", pd4, {10'h0, 10'h16, 10'h15, 10'h14});
                chk("t2_w2_podd", podd4, 3);
                chk("t2_lcnt", lc4, 7);
            end else begin
                chk("t2_no_de", de4, 0);
            end
        end
        step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // NUM_PIXELS=2: five pixels 0x20..0x24
        do_reset();
        n_de2 = 0;
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 10'(32'h20 + i), 1'b0, 1'b0, i == 4, 1'b0);
            if (i == 1) begin
                chk("t3_w1", pd2, {10'h21, 10'h20});
                chk("t3_w1_podd", podd2, 0);
            end
            if (i == 4) begin
                chk("t3_last", pd2, {10'h0, 10'h24});
                chk("t3_last_podd", podd2, 1);
            end
        end
        idle();
        chk("t3_n_de", n_de2, 3);
        chk("t3_lcnt", lc2, 5);

        // sof+sol together, eol+eof on the fourth pixel
        do_reset();
        step(1'b0, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_vs", vs4, 1);
        chk("t4_hs", hs4, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 10'(32'h40 + i), 1'b0, 1'b0, i == 4, i == 4);
        end
        chk("t4_de", de4, 1);
        chk("t4_data", pd4, {10'h44, 10'h43, 10'h42, 10'h41});
        chk("t4_podd", podd4, 0);
        chk("t4_fv_hi", fv4, 1);
        idle();
        chk("t4_fv_lo", fv4, 0);
        chk("t4_de_lo", de4, 0);
        chk("t4_err", err4, 0);

        // protocol errors
        do_reset();
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_err_pre", err4, 0);
        step(1'b1, 10'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_drop_de", de4, 0);
        chk("t5_err", err4, 1);
        step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10'h56, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h57, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_sof_de", de4, 0);
        chk("t5_sof_vs", vs4, 1);
        idle();
        chk("t5_after_de", de4, 0);
        chk("t5_err_sticky", err4, 1);

        // asynchronous reset with three lanes pending
        do_reset();
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 10'(32'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t6_fv_pre", fv4, 1);
        pix_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_fv_rst", fv4, 0);
        chk("t6_de_rst", de4, 0);
        chk("t6_data_rst", pd4, 0);
        chk("t6_podd_rst", podd4, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 10'(32'h70 + i), 1'b0, 1'b0, i == 4, 1'b0);
            if (i < 4) chk("t6_no_de", de4, 0);
        end
        chk("t6_de", de4, 1);
        chk("t6_data", pd4, {10'h74, 10'h73, 10'h72, 10'h71});
        chk("t6_podd", podd4, 0);
        chk("t6_err", err4, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
Synthesizable pixel-side output stage of the B2P path. It takes a one-pixel-per-cycle unpacked stream with frame and line markers and packs it into NUM_PIXELS-wide output words. It drives the frame_valid/line_valid/de/p_odd/vsync/hsync interface that the pixel monitor and downstream pixel consumers sample. It also reports per-line pixel counts and protocol errors for bench checking.

Parameters:
PIX_WIDTH, 10, bits per pixel.
NUM_PIXELS, 1, pixels per output word; legal values are 1, 2 and 4; any other value is a compile-time error.
CNT_W, 16, width of the line pixel counter.

Ports:
clk_pixel_i  in  1  pixel clock; the only clock.
reset_pixel_n_i  in  1  asynchronous active-low reset.
pix_vld_i  in  1  input pixel valid.
pix_data_i  in  PIX_WIDTH  input pixel.
sof_i  in  1  start-of-frame strobe.
sol_i  in  1  start-of-line strobe.
eol_i  in  1  end-of-line strobe; qualifies the last pixel when pix_vld_i=1.
eof_i  in  1  end-of-frame strobe.
pixel_data_o  out  PIX_WIDTH*NUM_PIXELS  packed word; lane k occupies bits [(k+1)*PIX_WIDTH-1 : k*PIX_WIDTH]; pixel 0 is in lane 0.
p_odd_o  out  2  valid-lane code.
line_valid_o  out  1  word valid within a line.
de_o  out  1  identical to line_valid_o.
frame_valid_o  out  1  frame active.
vsync_o  out  1  one-cycle pulse per accepted sof_i.
hsync_o  out  1  one-cycle pulse per accepted sol_i.
line_pix_cnt_o  out  CNT_W  pixel count of the last completed line.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset state:
  - All outputs are 0 and the FSM is in IDLE.
  - The lane index and pending buffer are cleared.
  - Reset asserted mid-line discards pending pixels immediately (asynchronous).
- FSM states IDLE, FRAME, LINE:
  - IDLE→FRAME on sof_i.
  - FRAME→LINE on sol_i.
  - LINE→FRAME on eol_i.
  - FRAME→IDLE on eof_i.
  - sof_i and sol_i in the same cycle: IDLE→LINE, with both vsync_o and hsync_o pulsing.
  - eol_i and eof_i in the same cycle: LINE→IDLE.
- Packing:
  - In LINE, each pix_vld_i=1 writes the pixel to the current lane; the lane index increments modulo NUM_PIXELS.
  - A word is emitted when the lane index wraps, or when eol_i is seen with ≥1 pending pixel.
  - Emission is registered: pixel_data_o, line_valid_o, de_o and p_odd_o are valid exactly 1 cycle after the completing input cycle.
  - line_valid_o=de_o=1 for only that one cycle per word; gaps between words are normal.
  - Unused lanes of a partial word are driven 0.
- p_odd_o encoding:
  - Equals (valid pixels in word) mod NUM_PIXELS: 00 = all lanes valid, 01 = lane 0 only, 10 = lanes 0-1, 11 = lanes 0-2.
  - Always 00 when NUM_PIXELS=1.
  - The lane index resets to 0 after every eol_i.
- eol_i handling:
  - eol_i with pix_vld_i=0 flushes any pending pixels.
  - If nothing is pending, eol_i is a no-op apart from the state change.
- Line counter:
  - Counts accepted pixels in LINE, saturating at 2^CNT_W-1.
  - The value is latched into line_pix_cnt_o in the cycle after eol_i, then the counter clears.
- Sync outputs:
  - vsync_o and frame_valid_o rise 1 cycle after sof_i.
  - hsync_o pulses 1 cycle after sol_i.
  - frame_valid_o falls 2 cycles after eof_i, so it is still high while a flushed final word is presented.
- sof_i while not IDLE: pending pixels are discarded, err_o is set, vsync_o pulses, and the FSM re-enters FRAME (LINE if sol_i is also asserted).
- err_o sets on any of the following; it is cleared only by reset:
  - pix_vld_i outside LINE (the pixel is dropped).
  - sol_i while in LINE.
  - eol_i or eof_i while in IDLE.
  - eof_i while in LINE without eol_i.
  - sof_i while not IDLE.

Test Plan:
1. NUM_PIXELS=1, frame of 2 lines × 3 pixels 0x001..0x006:
   - Six words with de_o=1 and p_odd_o=00, each 1 cycle after its input.
   - Two hsync_o pulses and one vsync_o pulse.
   - line_pix_cnt_o=3 after each eol_i.
   - frame_valid_o falls 2 cycles after eof_i.
2. NUM_PIXELS=4, line of 7 pixels 0x10..0x16:
   - Word 1 = {0x13,0x12,0x11,0x10} with p_odd_o=00.
   - Word 2 = {0,0x16,0x15,0x14} with p_odd_o=11.
   - line_pix_cnt_o=7.
3. NUM_PIXELS=2, line of 5 pixels:
   - Final word has lane 1 = 0 and p_odd_o=01.
   - Exactly 3 de_o pulses.
4. Simultaneous sof_i+sol_i, then eol_i+eof_i on pixel 4 (NUM_PIXELS=4):
   - vsync_o and hsync_o pulse in the same cycle.
   - A single word with p_odd_o=00 is presented while frame_valid_o=1.
   - frame_valid_o=0 one cycle later.
   - err_o=0.
5. Protocol errors:
   - pix_vld_i in FRAME state → pixel dropped, no de_o, err_o=1.
   - sof_i mid-line with 2 of 4 lanes pending → no word emitted, vsync_o pulses.
6. Reset mid-line with 3 of 4 lanes pending:
   - All outputs are 0 immediately.
   - A following clean 4-pixel line yields one word with p_odd_o=00.
